deal_sequencer: RTL
===================

Name: deal_sequencer

Overview:
Round controller for the blackjack game. Owns the single shared card source and sequences every draw through a req/ack handshake. The draw order is the initial deal (P, D, P, D), then player hits, then dealer auto-draw. The block accumulates both hands, decides win/lose, and holds the result until the next round. It sits between the debounced KEY inputs and the card generator, and drives the HEX/LEDR display logic.

Parameters:
DEALER_STAND, 17, dealer stops drawing once dhand >= this value
BLACKJACK, 21, target score; a hand above this is a bust

Ports:
Clock  input  1  system clock; all state changes on rising edge
reset_n  input  1  synchronous, active-low reset
enter  input  1  active-low button: start round / player hit
pass  input  1  active-low button: player stands
card_ack  input  1  card source: card_val valid this cycle
card_val  input  4  card value from source, legal range 1..10
card_req  output  1  request one card from the source
phand  output  5  player hand total
dhand  output  5  dealer hand total
pcard  output  4  last card dealt to the player
dcard  output  4  last card dealt to the dealer
result  output  2  00 none, 01 player win, 10 player lose
busy  output  1  high while any draw is outstanding
win_cnt  output  4  rounds won, wraps 15->0
loss_cnt  output  4  rounds lost, wraps 15->0

Behaviour:
- Reset: on a rising edge with reset_n=0, the block enters IDLE. All outputs go to 0, and the press-detect registers are set to 1 (released).
  - Reset wins over any other event that cycle, including card_ack.
  - Reset mid-draw drops card_req on the next cycle.
- Press detect: enter_q and pass_q are registered copies of the inputs.
  - A press is the cycle where the registered copy is 1 and the input is 0.
  - Held buttons give exactly one press.
  - If both press in the same cycle, enter wins and pass is ignored.
  - Presses in any state not listed below are ignored (including DEAL_* and *_HIT).
- States: IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, PLAYER, P_HIT, DEALER, D_HIT, WIN, LOSE.
- Moore output decode:
  - card_req = busy = 1 in DEAL_*, P_HIT and D_HIT.
  - result is decoded from WIN/LOSE.
- Handshake:
  - card_req stays high until card_ack is sampled high.
  - On that edge, the card is added to the target hand, the matching pcard/dcard is updated, and the state advances.
  - card_req is low in the following cycle, because the next draw state re-asserts it one cycle later. This gives a minimum of 1 idle cycle between draws.
  - card_ack while card_req=0 is ignored.
- Card clamp: card_val 0 counts as 1; 11..15 count as 10.
- Arithmetic: hands are 5-bit unsigned.
  - Maximum reachable value is 30 (player: 20+10; dealer: 16+10), so no overflow is possible.
- Transitions:
  - IDLE: enter press -> DEAL_P1.
  - Initial deal: DEAL_P1 -> DEAL_D1 -> DEAL_P2 -> DEAL_D2, each step on card_ack.
  - DEAL_D2 ack:
    - if phand == BLACKJACK -> WIN;
    - else -> PLAYER.
  - PLAYER:
    - enter press -> P_HIT;
    - pass press -> DEALER.
  - P_HIT ack, using the new phand:
    - == BLACKJACK -> WIN;
    - > BLACKJACK -> LOSE;
    - else -> PLAYER.
  - DEALER, evaluated one cycle after entry:
    - dhand < DEALER_STAND -> D_HIT;
    - else dhand > BLACKJACK -> WIN;
    - else dhand > phand -> LOSE;
    - else -> WIN (a tie goes to the player).
  - D_HIT ack -> DEALER.
  - WIN/LOSE: the result is held.
    - On entry to WIN, win_cnt increments once; on entry to LOSE, loss_cnt increments once.
    - An enter press clears phand, dhand, pcard and dcard, and goes to DEAL_P1 in the same edge.
    - pass is ignored.

Test Plan:
- Reset, then enter press; source acks each req after 2 cycles with 5,6,7,8 -> phand=12, dhand=14, state PLAYER, card_req low, result=00. Each card_req pulse lasts 3 cycles.
- From phand=12: enter press, card 9 -> phand=21, result=01, win_cnt=1. Second enter press starts a new round with hands cleared to 0.
- From phand=12: enter, card 10 -> phand=22, result=10, loss_cnt=1. Extra pass presses -> no req, no change.
- Player 18 / dealer 10: pass press, dealer draws 4 then 5 -> dhand=19 stops, result=10. Repeat with draws 3,10 -> dhand=23, result=01.
- Tie: phand=17, dhand=17 at pass -> no dealer draw, result=01. enter and pass pressed the same cycle in PLAYER -> P_HIT taken.
- Mid-draw: reset_n=0 while card_req high and card_ack high -> hands stay 0, card_req low next cycle. card_val=0 counts as 1 and card_val=13 counts as 10; holding enter low for 20 cycles -> exactly one draw.

Source files
------------

// File: rtl/deal_sequencer.sv
// Blackjack round controller: owns the shared card source handshake, accumulates
// both hands, runs the dealer auto-draw and holds the round result.
module deal_sequencer #(
    parameter int DEALER_STAND = 17,
    parameter int BLACKJACK    = 21
) (
    input  logic       Clock,
    input  logic       reset_n,
    input  logic       enter,
    input  logic       pass,
    input  logic       card_ack,
    input  logic [3:0] card_val,
    output logic       card_req,
    output logic [4:0] phand,
    output logic [4:0] dhand,
    output logic [3:0] pcard,
    output logic [3:0] dcard,
    output logic [1:0] result,
    output logic       busy,
    output logic [3:0] win_cnt,
    output logic [3:0] loss_cnt
);

    // state   | meaning
    // IDLE    | after reset, waiting for enter
    // DEAL_P1 | first card to player
    // DEAL_D1 | first card to dealer
    // DEAL_P2 | second card to player
    // DEAL_D2 | second card to dealer
    // PLAYER  | waiting for hit (enter) or stand (pass)
    // P_HIT   | drawing a player hit
    // DEALER  | dealer decides draw or settle
    // D_HIT   | drawing a dealer card
    // WIN     | player won, result held
    // LOSE    | player lost, result held
    typedef enum logic [3:0] {
        IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2,
        PLAYER, P_HIT, DEALER, D_HIT, WIN, LOSE
    } state_t;

    localparam logic [4:0] L_STAND = 5'(DEALER_STAND);
    localparam logic [4:0] L_BJ    = 5'(BLACKJACK);

    state_t     r_state, w_next;
    logic       r_enter_q, r_pass_q, r_gap;
    logic [4:0] r_phand, r_dhand;
    logic [3:0] r_pcard, r_dcard, r_win_cnt, r_loss_cnt;

    logic       w_enter_press, w_pass_press, w_draw, w_req, w_ack;
    logic       w_to_player, w_clear;
    logic [3:0] w_card;
    logic [4:0] w_phand_new, w_dhand_new;

    assign w_enter_press = r_enter_q & ~enter;
    assign w_pass_press  = r_pass_q & ~pass & ~w_enter_press;

    assign w_card = (card_val == 4'd0) ? 4'd1 :
                    (card_val > 4'd10) ? 4'd10 : card_val;

    assign w_phand_new = r_phand + {1'b0, w_card};
    assign w_dhand_new = r_dhand + {1'b0, w_card};

    assign w_draw = (r_state == DEAL_P1) || (r_state == DEAL_D1) ||
                    (r_state == DEAL_P2) || (r_state == DEAL_D2) ||
                    (r_state == P_HIT)   || (r_state == D_HIT);
    // r_gap forces one idle request cycle after every accepted card
    assign w_req       = w_draw & ~r_gap;
    assign w_ack       = card_ack & w_req;
    assign w_to_player = (r_state == DEAL_P1) || (r_state == DEAL_P2) || (r_state == P_HIT);
    assign w_clear     = ((r_state == WIN) || (r_state == LOSE)) && w_enter_press;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_enter_press) w_next = DEAL_P1;
            DEAL_P1: if (w_ack) w_next = DEAL_D1;
            DEAL_D1: if (w_ack) w_next = DEAL_P2;
            DEAL_P2: if (w_ack) w_next = DEAL_D2;
            DEAL_D2: if (w_ack) w_next = (r_phand == L_BJ) ? WIN : PLAYER;
            PLAYER: begin
                if (w_enter_press)     w_next = P_HIT;
                else if (w_pass_press) w_next = DEALER;
            end
            P_HIT: begin
                if (w_ack) begin
                    if (w_phand_new == L_BJ)     w_next = WIN;
                    else if (w_phand_new > L_BJ) w_next = LOSE;
                    else                         w_next = PLAYER;
                end
            end
            DEALER: begin
                if (r_dhand < L_STAND)      w_next = D_HIT;
                else if (r_dhand > L_BJ)    w_next = WIN;
                else if (r_dhand > r_phand) w_next = LOSE;
                else                        w_next = WIN;
            end
            D_HIT:   if (w_ack) w_next = DEALER;
            WIN,
            LOSE:    if (w_enter_press) w_next = DEAL_P1;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_enter_q  <= 1'b1;
            r_pass_q   <= 1'b1;
            r_gap      <= 1'b0;
            r_phand    <= '0;
            r_dhand    <= '0;
            r_pcard    <= '0;
            r_dcard    <= '0;
            r_win_cnt  <= '0;
            r_loss_cnt <= '0;
        end else begin
            r_state   <= w_next;
            r_enter_q <= enter;
            r_pass_q  <= pass;
            r_gap     <= w_ack;
            if (w_clear) begin
                r_phand <= '0;
                r_dhand <= '0;
                r_pcard <= '0;
                r_dcard <= '0;
            end else if (w_ack) begin
                if (w_to_player) begin
                    r_phand <= w_phand_new;
                    r_pcard <= w_card;
                end else begin
                    r_dhand <= w_dhand_new;
                    r_dcard <= w_card;
                end
            end
            if ((w_next == WIN) && (r_state != WIN))
                r_win_cnt <= r_win_cnt + 4'd1;
            if ((w_next == LOSE) && (r_state != LOSE))
                r_loss_cnt <= r_loss_cnt + 4'd1;
        end
    end

    assign card_req = w_req;
    assign busy     = w_req;
    assign phand    = r_phand;
    assign dhand    = r_dhand;
    assign pcard    = r_pcard;
    assign dcard    = r_dcard;
    assign result   = (r_state == WIN) ? 2'b01 : (r_state == LOSE) ? 2'b10 : 2'b00;
    assign win_cnt  = r_win_cnt;
    assign loss_cnt = r_loss_cnt;

endmodule
